fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between the fetch stage and the decode stage. Each cycle it accepts one fetched instruction with its PC and branch-prediction tag (prediction bit, predicted target). It presents the oldest entry to decode in show-ahead (first-word-fall-through) form. It back-pressures fetch when full. A branch misprediction flushes it in one cycle.

## Interface
Parameters:
- DEPTH, 4: number of entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- push_valid_i  input  1  fetch presents a valid instruction this cycle.
- pc_i  input  32  PC of the pushed instruction.
- instruction_i  input  32  pushed instruction word.
- br_pred_i  input  1  fetch predicted taken.
- new_pc_pred_i  input  32  predicted target.
- full_o  output  1  count == DEPTH; fetch must stall.
- pop_i  input  1  decode consumes the head entry this cycle.
- flush_i  input  1  misprediction or redirect; discard all entries.
- valid_o  output  1  head entry present (count != 0).
- pc_o  output  32  head PC.
- instruction_o  output  32  head instruction.
- br_pred_o  output  1  head prediction bit.
- new_pc_pred_o  output  32  head predicted target.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH entries of 97 bits, ordered {pc, instruction, br_pred, new_pc_pred}. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. A separate occupancy counter tracks count.
- Push accepted when push_valid_i && !full_o && !flush_i. The entry is written at wr_ptr, then wr_ptr increments.
- Push while full is dropped with no state change. Fetch must hold its instruction while full_o is high.
- full_o depends only on registered count. It never depends combinationally on pop_i, so there is no combinational loop through decode stall logic.
- Pop accepted when pop_i && valid_o && !flush_i. rd_ptr increments.
- Pop while empty is ignored.
- Push and pop accepted in the same cycle: count unchanged, both pointers advance.
- Flush has highest priority. On the next edge, rd_ptr, wr_ptr and count all go to 0. A push or pop in the flush cycle is discarded.
- Head outputs when valid_o=1: the entry at rd_ptr.
- Head outputs when valid_o=0: instruction_o = NOP (32'h00000013), pc_o=0, br_pred_o=0, new_pc_pred_o=0. Decode therefore never sees stale data.
- Storage contents are not reset. Forcing the head outputs on empty makes reset of storage unnecessary.

## Timing
- Reset (async assert, any cycle including mid-operation): pointers and count go to 0 immediately, and outputs go to the empty values. This gives valid_o=0, full_o=0, count_o=0, instruction_o=NOP, pc_o=0, br_pred_o=0, new_pc_pred_o=0.
- Push latency: an entry pushed at edge N is visible on the head outputs, with valid_o=1, from edge N onward (cycle N+1) when the queue was empty.
- Pop: the head advances at the edge where the pop is accepted. The next entry, or the empty values, appear in the following cycle.
- full_o rises the cycle after the DEPTH-th net push. It falls the cycle after the first accepted pop from full.
- Flush: valid_o=0 and count_o=0 in the cycle after flush_i is sampled high. A push in that following cycle is accepted normally.
- Throughput: one push and one pop per cycle in steady state. There is no bubble when the queue holds at least 1 entry.

## Structure
- Shared package (fetch_pkg):
  - NOP_INSTR = 32'h00000013.
  - FQ_ENTRY_W = 97.
  - Field offsets for the packed entry.
- Sub-module fetch_queue_ram: DEPTH×97 register array with one write port and one asynchronous read port.
- Pointer, count, flush and output-muxing logic lives in fetch_queue.

## Test plan
- Reset, then push 0x13/PC 0x0, 0x00500093/PC 0x4, 0x00A00113/PC 0x8 on consecutive cycles with pop_i=0:
  - count_o goes 1, 2, 3.
  - Head stays at PC 0x0.
  - Then pop three times: heads PC 0x4, PC 0x8, then valid_o=0 with instruction_o=NOP.
- Fill with 4 pushes, then hold push_valid_i on a 5th (PC 0x10):
  - full_o=1 and count_o=4.
  - PC 0x10 is not stored; draining yields exactly 4 entries.
- From count=2:
  - Push and pop together for 10 cycles: count_o stays 2, PCs emerge in order.
  - Pointers wrap past DEPTH-1 with no corruption.
- Fill 3 entries, then assert flush_i together with push_valid_i and pop_i:
  - Next cycle count_o=0 and valid_o=0.
  - A push the cycle after appears as the head.
- Push an entry with br_pred_i=1, new_pc_pred_i=0x40:
  - Head shows br_pred_o=1, new_pc_pred_o=0x40.
  - On the same cycle, deassert reset_n asynchronously: outputs clear immediately to the reset values.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode queue.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h00000013;
  localparam int          FQ_ENTRY_W = 97;

  // Bit offsets of each field inside a packed entry, MSB first: {pc, instr, br_pred, tgt}
  localparam int FQ_TGT_LSB   = 0;
  localparam int FQ_BRP_BIT   = 32;
  localparam int FQ_INSTR_LSB = 33;
  localparam int FQ_PC_LSB    = 65;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br_pred;
    logic [31:0] tgt;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: one write port, one asynchronous read port, contents not reset.
module fetch_queue_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Show-ahead fetch queue: pointers, occupancy, single-cycle flush and head muxing.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_valid_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              instruction_i,
  input  logic                     br_pred_i,
  input  logic [31:0]              new_pc_pred_i,
  output logic                     full_o,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [31:0]              pc_o,
  output logic [31:0]              instruction_o,
  output logic                     br_pred_o,
  output logic [31:0]              new_pc_pred_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok;
  fq_entry_t     wr_entry, head;

  // full/valid come only from the registered count, so decode stall logic
  // feeding pop_i can never loop back into full_o.
  assign full_o  = (count == FULL_CNT);
  assign valid_o = (count != '0);
  assign push_ok = push_valid_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && valid_o && !flush_i;
  assign count_o = count;

  assign wr_entry = '{pc: pc_i, instr: instruction_i, br_pred: br_pred_i, tgt: new_pc_pred_i};

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty queue presents a NOP so decode never sees stale storage.
  always_comb begin
    pc_o          = '0;
    instruction_o = NOP_INSTR;
    br_pred_o     = 1'b0;
    new_pc_pred_o = '0;
    if (valid_o) begin
      pc_o          = head.pc;
      instruction_o = head.instr;
      br_pred_o     = head.br_pred;
      new_pc_pred_o = head.tgt;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; a monitor checks every popped head against a scoreboard.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        push_valid_i, br_pred_i, pop_i, flush_i;
  logic [31:0] pc_i, instruction_i, new_pc_pred_i;
  logic        full_o, valid_o, br_pred_o;
  logic [31:0] pc_o, instruction_o, new_pc_pred_o;
  logic [2:0]  count_o;

  int errors = 0, checks = 0;
  int mon_errors = 0, mon_checks = 0;
  logic [96:0] sq [$];

  fetch_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid_i(push_valid_i), .pc_i(pc_i), .instruction_i(instruction_i),
    .br_pred_i(br_pred_i), .new_pc_pred_i(new_pc_pred_i), .full_o(full_o),
    .pop_i(pop_i), .flush_i(flush_i), .valid_o(valid_o), .pc_o(pc_o),
    .instruction_o(instruction_o), .br_pred_o(br_pred_o),
    .new_pc_pred_o(new_pc_pred_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Monitor: the head is consumed at the next edge whenever pop is accepted.
  always @(negedge clk) begin
    if (reset_n && valid_o && pop_i && !flush_i) begin
      mon_checks++;
      if (sq.size() == 0) begin
        mon_errors++;
        $display("FAIL pop_head: got pc=%h with no expected entry", pc_o);
      end else begin
        logic [96:0] exp_e;
        exp_e = sq.pop_front();
        if ({pc_o, instruction_o, br_pred_o, new_pc_pred_o} !== exp_e) begin
          mon_errors++;
          $display("FAIL pop_head: got %h required %h",
                   {pc_o, instruction_o, br_pred_o, new_pc_pred_o}, exp_e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                          input logic bp, input logic [31:0] tgt, input logic expect_acc);
    push_valid_i  = pv;
    pc_i          = pc;
    instruction_i = ins;
    br_pred_i     = bp;
    new_pc_pred_i = tgt;
    if (expect_acc) sq.push_back({pc, ins, bp, tgt});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
    chk({tag, "_instr"}, instruction_o, 32'h00000013);
    chk({tag, "_pc"}, pc_o, 32'd0);
    chk({tag, "_brp"}, 32'(br_pred_o), 32'd0);
    chk({tag, "_tgt"}, new_pc_pred_o, 32'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    pop_i = 1'b0;
    flush_i = 1'b0;
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    chk_empty("reset");
    reset_n = 1'b1;
    step();

    // Three pushes, head stays at the oldest entry
    set_push(1'b1, 32'h0, 32'h00000013, 1'b0, 32'h0, 1'b1);
    step(); chk("p1_count", 32'(count_o), 32'd1); chk("p1_head", pc_o, 32'h0);
    chk("p1_valid", 32'(valid_o), 32'd1);
    set_push(1'b1, 32'h4, 32'h00500093, 1'b0, 32'h0, 1'b1);
    step(); chk("p2_count", 32'(count_o), 32'd2); chk("p2_head", pc_o, 32'h0);
    set_push(1'b1, 32'h8, 32'h00A00113, 1'b0, 32'h0, 1'b1);
    step(); chk("p3_count", 32'(count_o), 32'd3); chk("p3_head", pc_o, 32'h0);
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    pop_i = 1'b1;
    step(); chk("pop1_head", pc_o, 32'h4); chk("pop1_instr", instruction_o, 32'h00500093);
    step(); chk("pop2_head", pc_o, 32'h8); chk("pop2_instr", instruction_o, 32'h00A00113);
    step(); chk("pop3_valid", 32'(valid_o), 32'd0); chk("pop3_instr", instruction_o, 32'h00000013);
    pop_i = 1'b0;

    // Fill to DEPTH, then a held fifth push must be dropped
    for (int i = 0; i < 4; i++) begin
      set_push(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b0, 32'h0, 1'b1);
      step();
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_count", 32'(count_o), 32'd4);
    set_push(1'b1, 32'h10, 32'h2000, 1'b0, 32'h0, 1'b0);
    step();
    chk("drop_full", 32'(full_o), 32'd1);
    chk("drop_count", 32'(count_o), 32'd4);
    chk("drop_head", pc_o, 32'h0);
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    pop_i = 1'b1;
    step();
    chk("unfull", 32'(full_o), 32'd0);
    n = 1;
    while (valid_o && n < 10) begin
      step();
      n++;
    end
    pop_i = 1'b0;
    chk("drain_n", 32'(n), 32'd4);

    // Steady-state push+pop at count 2; 12 pushes wrap both pointers
    set_push(1'b1, 32'h100, 32'h3000, 1'b0, 32'h0, 1'b1); step();
    set_push(1'b1, 32'h104, 32'h3001, 1'b1, 32'h500, 1'b1); step();
    chk("ss_start", 32'(count_o), 32'd2);
    pop_i = 1'b1;
    for (int i = 2; i < 12; i++) begin
      set_push(1'b1, 32'h100 + 32'(i * 4), 32'h3000 + 32'(i), i[0], 32'(i * 16), 1'b1);
      step();
      chk("ss_count", 32'(count_o), 32'd2);
    end
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(); step();
    pop_i = 1'b0;
    chk("ss_empty", 32'(valid_o), 32'd0);
    chk("ss_sb", 32'(sq.size()), 32'd0);

    // Flush beats a simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      set_push(1'b1, 32'h200 + 32'(i * 4), 32'h4000 + 32'(i), 1'b0, 32'h0, 1'b0);
      step();
    end
    set_push(1'b1, 32'h300, 32'h5000, 1'b0, 32'h0, 1'b0);
    flush_i = 1'b1;
    pop_i = 1'b1;
    step();
    flush_i = 1'b0;
    pop_i = 1'b0;
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    set_push(1'b1, 32'h400, 32'h6000, 1'b0, 32'h0, 1'b1);
    step();
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("postflush_head", pc_o, 32'h400);
    chk("postflush_count", 32'(count_o), 32'd1);
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    chk("postflush_sb", 32'(sq.size()), 32'd0);

    // Prediction fields, then asynchronous reset mid-cycle
    set_push(1'b1, 32'h500, 32'h7000, 1'b1, 32'h40, 1'b0);
    step();
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("bp_head", 32'(br_pred_o), 32'd1);
    chk("bp_tgt", new_pc_pred_o, 32'h40);
    #2;
    reset_n = 1'b0;
    #1;
    chk_empty("async_rst");
    step();
    reset_n = 1'b1;
    step();
    chk("after_rst_valid", 32'(valid_o), 32'd0);

    errors += mon_errors;
    checks += mon_checks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
